// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin write-port arbiter placed in front of async_fifo. It grants one
// requester at a time for a burst of up to MAX_BURST beats, forwards that
// requester's data to the FIFO write port and stalls while the FIFO is full.
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    input  logic                          fifo_full_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;

    logic                found;
    logic [IDX_W-1:0]    winner;
    logic                granted_valid;
    logic                beat_xfer;
    logic                burst_done;

    // Round-robin search starting just after the last granted index and ending
    // with that index itself; scanning from the far end lets the nearest hit win.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        found  = 1'b0;
        winner = last_q;
        idx    = 0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx  = (int'(last_q) + k) % NUM_REQ;
            cand = IDX_W'(idx);
            if (req_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // While granted, last_q holds the granted index, so the grant mask alone
    // tells whether the owner is presenting a beat.
    always_comb begin
        granted_valid = |(req_valid_i & grant_q);
        beat_xfer     = (state_q == GRANT) && granted_valid && !fifo_full_i;
        burst_done    = beat_xfer && ((beats_q + BEAT_W'(1)) == BEAT_W'(MAX_BURST));
    end

    // Next-state logic: grant from IDLE, count beats, and hand over directly to
    // the next winner on release so back-to-back bursts have no idle bubble.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    last_d  = winner;
                    beats_d = '0;
                end
            end
            GRANT: begin
                if (burst_done || !granted_valid) begin
                    beats_d = '0;
                    if (found) begin
                        grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                        last_d  = winner;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (beat_xfer) begin
                    beats_d = beats_q + BEAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                beats_d = '0;
            end
        endcase
    end

    // State registers; reset points last at NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    // FIFO-side and requester-side outputs, all derived from the registered grant.
    always_comb begin
        fifo_wr_en_o   = beat_xfer;
        req_ready_o    = grant_q & {NUM_REQ{~fifo_full_i}};
        grant_o        = grant_q;
        busy_o         = (state_q == GRANT);
        fifo_wr_data_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                fifo_wr_data_o = fifo_wr_data_o | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: doc/async_fifo_wr_arbiter.md
# async_fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of `async_fifo` between `NUM_REQ` requesters in the write-clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a burst of up to `MAX_BURST` beats and forwards its data to the FIFO, stalling on `full`. It sits directly in front of `async_fifo` (`wr_clk_i`/`wr_en_i`/`wr_data_i`/`full_o`) and is the only driver of that port.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, default 8: beat width; must match the FIFO `DATA_WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant; legal range 1..255.

Ports:
- `clk_i`  in  1: the one clock; connect to the FIFO `wr_clk_i`.
- `rstn_i`  in  1: asynchronous reset, active-low.
- `req_valid_i`  in  NUM_REQ: per-requester beat valid.
- `req_data_i`  in  NUM_REQ*DATA_WIDTH: requester i's data is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready_o`  out  NUM_REQ: per-requester beat accepted this cycle.
- `fifo_wr_en_o`  out  1: to the FIFO `wr_en_i`.
- `fifo_wr_data_o`  out  DATA_WIDTH: to the FIFO `wr_data_i`.
- `fifo_full_i`  in  1: from the FIFO `full_o`.
- `grant_o`  out  NUM_REQ: one-hot current grant; all zero when idle.
- `busy_o`  out  1: high in state GRANT.

## Operation
- The FSM has two states, IDLE and GRANT. The registered state is: state, `grant_o`, the round-robin pointer `last` (index of the last granted requester), and the beat counter `beats` (width clog2(MAX_BURST+1)).
- **IDLE:**
  - If `req_valid_i` is non-zero, pick the first valid index searching `last+1`, `last+2`, … mod NUM_REQ, ending with `last` itself.
  - On the next edge: load `grant_o` with that index, set `last` to the index, clear `beats`, and go to GRANT.
- **GRANT, granted requester g:**
  - A beat transfers when `req_valid_i[g]` is high and `fifo_full_i` is low.
  - Each beat increments `beats`.
- **Release** happens at an edge where either:
  - (a) a beat transfers and `beats+1 == MAX_BURST`, or
  - (b) `req_valid_i[g]` is low.
- **On release:** run the same round-robin search over the current `req_valid_i`. In case (a), requester g is included but searched last. In case (b), g is not valid, so it is excluded.
  - If a winner exists, move to GRANT on the winner directly, with no idle bubble: reload `grant_o`, set `last`, clear `beats`.
  - Otherwise go to IDLE with `grant_o` = 0.
- `fifo_full_i` high stalls the burst. The stalled cycle neither counts a beat nor causes a release, as long as valid stays high.
- Combinational outputs:
  - `fifo_wr_en_o` = (state==GRANT) & `req_valid_i[g]` & !`fifo_full_i`
  - `req_ready_o[i]` = `grant_o[i]` & !`fifo_full_i`
  - `fifo_wr_data_o` = `req_data_i` slice g when granted, else 0.
- Requester protocol: data must be held stable while valid is high and ready is low. Dropping valid ends the burst.
- Data order within a requester is preserved. There is no reordering and no beat loss or duplication.

## Timing
- **Reset** (asynchronous, any time): state=IDLE, `grant_o`=0, `last`=NUM_REQ-1 (so requester 0 wins first), `beats`=0.
  - This forces `fifo_wr_en_o`=0, `fifo_wr_data_o`=0, `req_ready_o`=0 and `busy_o`=0 immediately.
  - A beat pending at the reset edge is not written.
- Arbitration latency from IDLE: valid seen at edge n gives grant from edge n+1. The first possible write is at edge n+2.
- Throughput: one beat per clock while granted and not full. Back-to-back bursts between requesters have zero dead cycles.
- Simultaneous full deassert and release check: release is evaluated with the current `fifo_full_i` only through the beat-transfer term.
- With MAX_BURST=1, the grant rotates after every beat when other requesters are valid.
- `last` wraps modulo NUM_REQ. A burst counter overflow is impossible because the counter is cleared at release.

## Test plan
- **Single requester:** NUM_REQ=4, MAX_BURST=4; requester 2 streams 0x10..0x19 continuously with FIFO never full → grant first at edge 1, FIFO receives 0x10..0x19 in order, grant re-issued to 2 after every 4 beats with no gap, exactly 10 `wr_en` pulses.
- **All four requesters valid after reset**, each sending tag (i<<4)|k → FIFO order is req0 k0-3, req1 k0-3, req2 k0-3, req3 k0-3, then req0 again; `grant_o` sequence 0001, 0010, 0100, 1000.
- **Full back-pressure:** `fifo_full_i` forced high for 5 cycles mid-burst after beat 2 of requester 1 → `fifo_wr_en_o` and `req_ready_o` low for those 5 cycles, grant held, beats 3-4 follow when full drops, no beat lost or duplicated.
- **Early release:** requester 3 drops valid after 1 beat while requester 0 is valid → next edge grants requester 0 directly (no IDLE cycle), requester 3 total accepted = 1.
- **Reset mid-burst:** `rstn_i` pulsed low for 3 ns while requester 1 is granted → `grant_o`=0, `fifo_wr_en_o`=0 asynchronously. After release, with req1 and req2 valid, requester 0's priority position applies: req1 wins first.
- **End-to-end:** arbiter plus `async_fifo` (FIFO_DEPTH 8, wr 20 ns / rd 14 ns clocks), 4 requesters × 32 random beats → the reader's per-requester subsequences match the sent order exactly.
